// File: rtl/tm1638_responder.sv
// TM1638 responder: samples the STB/CLK/DIO link, holds display RAM and control state,
// and shifts a key snapshot back on reads. `TM1638_RSP_ERR_EN builds the sticky proto_err logic.
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tm1638_clk,
  input  logic        tm1638_stb,
  input  logic        tm1638_dio_in,
  output logic        tm1638_dio_out,
  output logic        tm1638_dio_out_en,
  input  logic [31:0] key_in,
  input  logic [3:0]  ram_rd_addr,
  output logic [7:0]  ram_rd_data,
  output logic        ram_wr,
  output logic [3:0]  ram_wr_addr,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        proto_err
);

  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KEY_W     = 32;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;

  // Link synchronizers plus edge-detect copies; everything idles high
  logic [SYNC_STAGES-1:0] clk_sync_q, stb_sync_q, dio_sync_q;
  logic clk_prev_q, stb_prev_q;
  logic clk_s, stb_s, dio_s;
  logic clk_rise, clk_fall, stb_rise, stb_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      stb_sync_q <= '1;
      dio_sync_q <= '1;
      clk_prev_q <= 1'b1;
      stb_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], tm1638_clk};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], tm1638_stb};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], tm1638_dio_in};
      clk_prev_q <= clk_s;
      stb_prev_q <= stb_s;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign dio_s    = dio_sync_q[SYNC_STAGES-1];
  assign clk_rise =  clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s &  clk_prev_q;
  assign stb_rise =  stb_s & ~stb_prev_q;
  assign stb_fall = ~stb_s &  stb_prev_q;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d, byte_c;
  logic                fixed_q, fixed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [KEY_W-1:0]    snap_q, snap_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic                dio_out_q, dio_out_d;
  logic                dio_en_q, dio_en_d;
  logic                disp_on_q, disp_on_d;
  logic [2:0]          bright_q, bright_d;
  logic                ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]   ram_wr_addr_q, ram_wr_addr_d;
  logic                ram_we;
  logic [BYTE_W-1:0]   ram_q [RAM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      fixed_q       <= 1'b0;
      addr_q        <= '0;
      snap_q        <= '0;
      rd_idx_q      <= '0;
      dio_out_q     <= 1'b0;
      dio_en_q      <= 1'b0;
      disp_on_q     <= 1'b0;
      bright_q      <= '0;
      ram_wr_q      <= 1'b0;
      ram_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      fixed_q       <= fixed_d;
      addr_q        <= addr_d;
      snap_q        <= snap_d;
      rd_idx_q      <= rd_idx_d;
      dio_out_q     <= dio_out_d;
      dio_en_q      <= dio_en_d;
      disp_on_q     <= disp_on_d;
      bright_q      <= bright_d;
      ram_wr_q      <= ram_wr_d;
      ram_wr_addr_q <= ram_wr_addr_d;
    end
  end

  // Byte being assembled, including the bit arriving on this CLK rise
  always_comb begin
    byte_c          = shreg_q;
    byte_c[bit_cnt_q] = dio_s;
  end

  // Next-state and datapath; an STB edge pre-empts any CLK edge in the same cycle
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    fixed_d       = fixed_q;
    addr_d        = addr_q;
    snap_d        = snap_q;
    rd_idx_d      = rd_idx_q;
    dio_out_d     = dio_out_q;
    dio_en_d      = dio_en_q;
    disp_on_d     = disp_on_q;
    bright_d      = bright_q;
    ram_wr_d      = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_we        = 1'b0;

    if (stb_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
      shreg_d   = '0;
      dio_en_d  = 1'b0;
    end else if (stb_rise) begin
      state_d  = IDLE;
      dio_en_d = 1'b0;
    end else begin
      case (state_q)
        CMD, WDATA: begin
          if (clk_rise) begin
            shreg_d   = byte_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              shreg_d = '0;
              if (state_q == CMD) begin
                case (byte_c[7:6])
                  2'b01: begin
                    fixed_d = byte_c[2];
                    if (byte_c[1]) begin
                      snap_d   = key_in;
                      rd_idx_d = '0;
                      state_d  = RDATA;
                    end else begin
                      state_d  = IGNORE;
                    end
                  end
                  2'b10: begin
                    disp_on_d = byte_c[3];
                    bright_d  = byte_c[2:0];
                    state_d   = IGNORE;
                  end
                  2'b11: begin
                    addr_d  = byte_c[ADDR_W-1:0];
                    state_d = WDATA;
                  end
                  default: state_d = IGNORE;
                endcase
              end else begin
                ram_we        = 1'b1;
                ram_wr_d      = 1'b1;
                ram_wr_addr_d = addr_q;
                if (!fixed_q) addr_d = addr_q + 4'd1;
              end
            end
          end
        end
        RDATA: begin
          if (clk_fall) begin
            dio_out_d = snap_q[rd_idx_q];
            dio_en_d  = 1'b1;
          end else if (clk_rise) begin
            rd_idx_d = rd_idx_q + 5'd1;
            if (rd_idx_q == 5'd31) begin
              dio_en_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        IGNORE: begin
          if (clk_rise) bit_cnt_d = bit_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Display RAM; reads see pre-write contents in the write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      ram_q[addr_q] <= byte_c;
    end
  end

  assign ram_rd_data       = ram_q[ram_rd_addr];
  assign tm1638_dio_out    = dio_out_q;
  assign tm1638_dio_out_en = dio_en_q;
  assign ram_wr            = ram_wr_q;
  assign ram_wr_addr       = ram_wr_addr_q;
  assign display_on        = disp_on_q;
  assign brightness        = bright_q;

`ifdef TM1638_RSP_ERR_EN
  logic err_ev;
  logic err_q;

  // Error events: 00 command, byte completed in IGNORE, STB rise mid-byte
  always_comb begin
    err_ev = 1'b0;
    if (stb_rise) begin
      err_ev = ((state_q == CMD) || (state_q == WDATA)) && (bit_cnt_q != 3'd0);
    end else if (!stb_fall && clk_rise && (bit_cnt_q == 3'd7)) begin
      err_ev = (state_q == IGNORE) || ((state_q == CMD) && (byte_c[7:6] == 2'b00));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (err_ev) err_q <= 1'b1;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: vector table of write/control transactions,
// then hand sequences for key read, partial byte abort and error reporting.
module tb_tm1638_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tclk = 1'b1;
  logic        tstb = 1'b1;
  logic        tdio = 1'b1;
  logic        dio_out, dio_out_en;
  logic [31:0] key_in = '0;
  logic [3:0]  ram_rd_addr = '0;
  logic [7:0]  ram_rd_data;
  logic        ram_wr;
  logic [3:0]  ram_wr_addr;
  logic        display_on;
  logic [2:0]  brightness;
  logic        proto_err;

`ifdef TM1638_RSP_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .tm1638_clk(tclk), .tm1638_stb(tstb), .tm1638_dio_in(tdio),
    .tm1638_dio_out(dio_out), .tm1638_dio_out_en(dio_out_en),
    .key_in(key_in), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr),
    .display_on(display_on), .brightness(brightness), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [3:0] wr_q[$];

  always @(negedge clk) if (ram_wr) wr_q.push_back(ram_wr_addr);

  typedef struct {
    logic [31:0] bytes;  // first byte sent in bits 7:0
    int          n;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        don;
    logic [2:0]  bri;
    int          nwr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tclk = 1'b0;
      tdio = b[i];
      wait_clks(6);
      tclk = 1'b1;
      wait_clks(6);
    end
  endtask

  task automatic txn(input logic [31:0] bytes, input int n);
    tstb = 1'b0;
    wait_clks(6);
    for (int k = 0; k < n; k++) send_bits(bytes[k*8 +: 8], 8);
    tstb = 1'b1;
    wait_clks(6);
  endtask

  task automatic rd_ram(input logic [3:0] a, output logic [7:0] d);
    ram_rd_addr = a;
    #1;
    d = ram_rd_data;
  endtask

  initial begin
    vec_t        vecs[10];
    logic [7:0]  exp_ram[16];
    logic [3:0]  exp_addr[9];
    logic [7:0]  d;
    logic [31:0] rd;
    logic        en_all;
    int          nbefore;

    vecs[0] = '{32'h0000_0040,   1, 4'd0,  8'h00, 1'b0, 3'd0, 0};
    vecs[1] = '{32'h3322_11C0,   4, 4'd0,  8'h11, 1'b0, 3'd0, 3};
    vecs[2] = '{32'h0000_0044,   1, 4'd1,  8'h22, 1'b0, 3'd0, 0};
    vecs[3] = '{32'h0055_AAC5,   3, 4'd5,  8'h55, 1'b0, 3'd0, 2};
    vecs[4] = '{32'h0000_008F,   1, 4'd6,  8'h00, 1'b1, 3'd7, 0};
    vecs[5] = '{32'h0088_77C6,   3, 4'd6,  8'h88, 1'b1, 3'd7, 2};
    vecs[6] = '{32'h0000_0040,   1, 4'd7,  8'h00, 1'b1, 3'd7, 0};
    vecs[7] = '{32'h00B2_A1CF,   3, 4'd15, 8'hA1, 1'b1, 3'd7, 2};
    vecs[8] = '{32'h0000_0080,   1, 4'd0,  8'hB2, 1'b0, 3'd0, 0};
    vecs[9] = '{32'h0000_00C2,   1, 4'd2,  8'h33, 1'b0, 3'd0, 0};
    exp_addr = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd6, 4'd6, 4'd15, 4'd0};
    for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
    exp_ram[0] = 8'hB2; exp_ram[1] = 8'h22; exp_ram[2] = 8'h33;
    exp_ram[5] = 8'h55; exp_ram[6] = 8'h88; exp_ram[15] = 8'hA1;

    // Reset state
    wait_clks(3);
    chk("rst_dio_en", 32'(dio_out_en), 32'd0);
    chk("rst_dio_out", 32'(dio_out), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_display", 32'({display_on, brightness}), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    rd_ram(4'd0, d);
    chk("rst_ram0", 32'(d), 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    // Write / control transactions
    for (int v = 0; v < 10; v++) begin
      nbefore = wr_q.size();
      txn(vecs[v].bytes, vecs[v].n);
      chk($sformatf("v%0d_nwr", v), 32'(wr_q.size() - nbefore), 32'(vecs[v].nwr));
      rd_ram(vecs[v].addr, d);
      chk($sformatf("v%0d_ram", v), 32'(d), 32'(vecs[v].data));
      chk($sformatf("v%0d_don", v), 32'(display_on), 32'(vecs[v].don));
      chk($sformatf("v%0d_bri", v), 32'(brightness), 32'(vecs[v].bri));
    end

    chk("wr_count", 32'(wr_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < wr_q.size(); i++)
      chk($sformatf("wr_addr%0d", i), 32'(wr_q[i]), 32'(exp_addr[i]));
    for (int a = 0; a < 16; a++) begin
      rd_ram(4'(a), d);
      chk($sformatf("ram%0d", a), 32'(d), 32'(exp_ram[a]));
    end

    // Key read: snapshot taken at command decode, later key_in changes ignored
    key_in = 32'h0403_0201;
    tstb = 1'b0;
    wait_clks(6);
    send_bits(8'h42, 8);
    chk("rd_en_before", 32'(dio_out_en), 32'd0);
    rd = '0;
    en_all = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 8) key_in = 32'hFFFF_0000;
      tclk = 1'b0;
      wait_clks(6);
      rd[i] = dio_out;
      en_all = en_all & dio_out_en;
      tclk = 1'b1;
      wait_clks(6);
    end
    chk("rd_data", rd, 32'h0403_0201);
    chk("rd_en_during", 32'(en_all), 32'd1);
    chk("rd_en_after31", 32'(dio_out_en), 32'd0);
    tclk = 1'b0;
    wait_clks(6);
    chk("rd_en_extra_fall", 32'(dio_out_en), 32'd0);
    tclk = 1'b1;
    wait_clks(6);
    tstb = 1'b1;
    wait_clks(6);
    chk("rd_en_stb_rise", 32'(dio_out_en), 32'd0);
    chk("rd_no_err", 32'(proto_err), 32'd0);

    // 0x42 cleared fixed mode: auto-increment again
    txn(32'h0002_01C8, 3);
    rd_ram(4'd8, d);
    chk("inc_ram8", 32'(d), 32'h01);
    rd_ram(4'd9, d);
    chk("inc_ram9", 32'(d), 32'h02);

    // STB raised after 4 bits of a data byte
    nbefore = wr_q.size();
    tstb = 1'b0;
    wait_clks(6);
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 4);
    tstb = 1'b1;
    wait_clks(6);
    chk("part_nwr", 32'(wr_q.size() - nbefore), 32'd0);
    rd_ram(4'd3, d);
    chk("part_ram3", 32'(d), 32'h00);
    chk("part_err", 32'(proto_err), 32'(ERR_ON));
    txn(32'h0000_5AC3, 2);
    rd_ram(4'd3, d);
    chk("after_part_ram3", 32'(d), 32'h5A);
    chk("after_part_nwr", 32'(wr_q.size() - nbefore), 32'd1);

    // Reset clears everything, then a 00 command on its own
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(2);
    chk("rst2_err", 32'(proto_err), 32'd0);
    rd_ram(4'd3, d);
    chk("rst2_ram3", 32'(d), 32'h00);
    txn(32'h0000_0000, 1);
    chk("cmd00_err", 32'(proto_err), 32'(ERR_ON));
    chk("cmd00_display", 32'({display_on, brightness}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
